multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port Clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port Instruction, input, 32: instruction-memory read data at address PC, combinational.
REQ-004 SHALL have port Zero, input, 1: ALU zero flag.
REQ-005 SHALL have port DataReady, input, 1: data-memory acknowledge for the current read or write.
REQ-006 SHALL have port Stall, input, 1: hold in FETCH while high.
REQ-007 SHALL have port PC, output, 8: instruction-memory byte address.
REQ-008 SHALL have port IR, output, 32: latched instruction.
REQ-009 SHALL have ports RegWrite, MemRead, MemWrite, RegDst, MemtoReg and ALUSrc, each output, 1: datapath controls.
REQ-010 SHALL have port ALUCtl, output, 3: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT.
REQ-011 SHALL have port State, output, 4: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, HALT=9.
REQ-012 SHALL have port Halt, output, 1: high only in HALT.
REQ-013 SHALL have port InstrCount, output, 16: retired-instruction count.

Function
REQ-014 Control outputs SHALL be a Moore decode of State and IR; every control not listed for a state SHALL be 0, and ALUCtl SHALL default to 010.
REQ-015 FETCH with Stall=0: IR<=Instruction, PC<=PC+4 (mod 256, so 252 wraps to 0), then DECODE. With Stall=1: hold all registers.
REQ-016 DECODE SHALL dispatch on IR[31:26]:
- 0x23 or 0x2B -> MEMADR.
- 0x00 with funct (IR[5:0]) in {0x20, 0x22, 0x24, 0x25, 0x2A} -> EXEC; any other funct -> HALT.
- 0x04 -> see Configuration.
- Any other opcode -> HALT.
REQ-017 MEMADR: ALUSrc=1, ALUCtl=010; go to MEMRD if opcode is 0x23, otherwise MEMWR.
REQ-018 MEMRD: MemRead=1; stay until DataReady=1, then MEMWB.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
REQ-020 MEMWR: MemWrite=1; stay until DataReady=1, then FETCH.
REQ-021 EXEC: ALUSrc=0; ALUCtl from funct: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2A->111; then ALUWB.
REQ-022 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, ALUCtl held from EXEC; then FETCH.
REQ-023 BRANCH: ALUSrc=0, ALUCtl=110; if Zero=1, PC<=PC+(sign-extended IR[15:0]<<2), truncated to 8 bits, where PC already holds the address+4; then FETCH.
REQ-024 HALT SHALL be terminal: PC, IR and InstrCount frozen, all controls 0, until Reset.
REQ-025 InstrCount SHALL increment (wrapping at 16 bits) on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH.
REQ-026 Latency with DataReady=1: lw 5 cycles; sw 4; R-type 4; beq 3.
REQ-027 Stall SHALL be ignored outside FETCH; DataReady SHALL be ignored outside MEMRD and MEMWR.

Reset
REQ-028 When Reset=1 at a rising edge: State=FETCH, PC=0, IR=0, InstrCount=0; all controls then 0, Halt=0.
REQ-029 Reset SHALL take priority over every transition, including mid-wait in MEMRD/MEMWR and in HALT.

Configuration
REQ-030 Macro MULTICYCLE_CTRL_BEQ_EN defined: opcode 0x04 in DECODE -> BRANCH per REQ-023.
REQ-031 Macro undefined: BRANCH unreachable; opcode 0x04 -> HALT.

Verification
REQ-032 Reset, DataReady=1, Instruction={0x23,0,5,20} at PC=0 -> State 0,1,2,3,4,0; MemRead=1 in MEMRD; RegWrite=1, MemtoReg=1 in MEMWB; PC=4 after FETCH; InstrCount=1.
REQ-033 R-type sequence add/sub/and/or/slt (funct 0x20, 0x22, 0x24, 0x25, 0x2A) -> ALUCtl 010/110/000/001/111 in EXEC; RegWrite=1, RegDst=1 in ALUWB; 4 cycles each; InstrCount increments by 5.
REQ-034 sw {0x2B,0,11,0} with DataReady=0 for 3 cycles in MEMWR, then 1 -> MemWrite=1 for 4 cycles, then FETCH; PC advanced by exactly 4.
REQ-035 Opcode 0x3F, or R-type funct 0x00 -> Halt=1 the cycle after DECODE; PC frozen over 10 cycles; Reset -> State=0, PC=0.
REQ-036 With MULTICYCLE_CTRL_BEQ_EN, beq at PC=12, imm=0xFFFD:
- Zero=1 -> PC=4.
- Zero=0 -> PC=16.
- Without the macro -> Halt=1.
REQ-037 Reset asserted in MEMRD with DataReady=0, and separately PC=252 fetch -> next cycle State=0, MemRead=0, PC=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control unit for a small MIPS-style multicycle datapath.
// Sequences fetch/decode/execute for lw, sw and five R-type ALU ops, owns the
// PC and instruction register, and counts retired instructions.
// Optional feature: define MULTICYCLE_CTRL_BEQ_EN to enable beq (opcode 0x04).
// Without it, beq is treated as an illegal opcode and halts the machine.
// Every output is registered: next-state logic also pre-decodes the controls
// for the next state, so controls always line up with State.

module multicycle_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic        Zero,
  input  logic        DataReady,
  input  logic        Stall,
  output logic [7:0]  PC,
  output logic [31:0] IR,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [2:0]  ALUCtl,
  output logic [3:0]  State,
  output logic        Halt,
  output logic [15:0] InstrCount
);

  // Encoded so that State can be exported as-is.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // True for the R-type functs this controller knows how to execute.
  function automatic logic funct_supported(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_supported = 1'b1;
      default:                               funct_supported = 1'b0;
    endcase
  endfunction

  // ALU operation selected by an R-type funct field.
  function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  funct_to_alu = ALU_SUB;
      FN_AND:  funct_to_alu = ALU_AND;
      FN_OR:   funct_to_alu = ALU_OR;
      FN_SLT:  funct_to_alu = ALU_SLT;
      default: funct_to_alu = ALU_ADD;
    endcase
  endfunction

  state_t      state_reg, state_next;
  logic [7:0]  pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic [15:0] count_reg, count_next;

  logic        reg_write_reg, reg_write_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic        reg_dst_reg, reg_dst_next;
  logic        mem_to_reg_reg, mem_to_reg_next;
  logic        alu_src_reg, alu_src_next;
  logic [2:0]  alu_ctl_reg, alu_ctl_next;
  logic        halt_reg, halt_next;

  logic [5:0]  opcode;
  logic [5:0]  funct;

  assign opcode = ir_reg[31:26];
  assign funct  = ir_reg[5:0];

  // Next-state, PC, IR and retired-count logic.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    count_next = count_reg;

    case (state_reg)
      S_FETCH: begin
        // A stall freezes everything, including the PC increment.
        if (!Stall) begin
          ir_next    = Instruction;
          pc_next    = pc_reg + 8'd4;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = funct_supported(funct) ? S_EXEC : S_HALT;
`ifdef MULTICYCLE_CTRL_BEQ_EN
          OP_BEQ:       state_next = S_BRANCH;
`endif
          default:      state_next = S_HALT;
        endcase
      end

      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;

      S_MEMRD: begin
        if (DataReady) begin
          state_next = S_MEMWB;
        end
      end

      S_MEMWB: begin
        state_next = S_FETCH;
        count_next = count_reg + 16'd1;
      end

      S_MEMWR: begin
        if (DataReady) begin
          state_next = S_FETCH;
          count_next = count_reg + 16'd1;
        end
      end

      S_EXEC: state_next = S_ALUWB;

      S_ALUWB: begin
        state_next = S_FETCH;
        count_next = count_reg + 16'd1;
      end

      S_BRANCH: begin
        // PC already points past the beq. Only the low 8 bits of the
        // sign-extended, word-scaled offset survive truncation, and those
        // are exactly imm[5:0] followed by two zero bits.
        if (Zero) begin
          pc_next = pc_reg + {ir_reg[5:0], 2'b00};
        end
        state_next = S_FETCH;
        count_next = count_reg + 16'd1;
      end

      S_HALT: state_next = S_HALT;

      default: state_next = S_HALT;
    endcase
  end

  // Moore control decode for the state being entered, so the registered
  // controls are valid in the same cycle that State shows that state.
  always_comb begin
    reg_write_next  = 1'b0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    reg_dst_next    = 1'b0;
    mem_to_reg_next = 1'b0;
    alu_src_next    = 1'b0;
    alu_ctl_next    = ALU_ADD;
    halt_next       = 1'b0;

    case (state_next)
      S_MEMADR: begin
        alu_src_next = 1'b1;
        alu_ctl_next = ALU_ADD;
      end
      S_MEMRD:  mem_read_next = 1'b1;
      S_MEMWB: begin
        reg_write_next  = 1'b1;
        mem_to_reg_next = 1'b1;
      end
      S_MEMWR:  mem_write_next = 1'b1;
      S_EXEC:   alu_ctl_next = funct_to_alu(ir_next[5:0]);
      S_ALUWB: begin
        reg_write_next = 1'b1;
        reg_dst_next   = 1'b1;
        // Keep the operation the ALU computed in EXEC through write-back.
        alu_ctl_next   = alu_ctl_reg;
      end
      S_BRANCH: alu_ctl_next = ALU_SUB;
      S_HALT: begin
        // Halted machine drives every control, including the ALU op, low.
        alu_ctl_next = 3'b000;
        halt_next    = 1'b1;
      end
      default: ;
    endcase
  end

  // State register and registered outputs; reset wins over every transition.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= S_FETCH;
      pc_reg         <= 8'd0;
      ir_reg         <= 32'd0;
      count_reg      <= 16'd0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      reg_dst_reg    <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      alu_src_reg    <= 1'b0;
      alu_ctl_reg    <= ALU_ADD;
      halt_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      ir_reg         <= ir_next;
      count_reg      <= count_next;
      reg_write_reg  <= reg_write_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      reg_dst_reg    <= reg_dst_next;
      mem_to_reg_reg <= mem_to_reg_next;
      alu_src_reg    <= alu_src_next;
      alu_ctl_reg    <= alu_ctl_next;
      halt_reg       <= halt_next;
    end
  end

  assign State      = state_reg;
  assign PC         = pc_reg;
  assign IR         = ir_reg;
  assign InstrCount = count_reg;
  assign RegWrite   = reg_write_reg;
  assign MemRead    = mem_read_reg;
  assign MemWrite   = mem_write_reg;
  assign RegDst     = reg_dst_reg;
  assign MemtoReg   = mem_to_reg_reg;
  assign ALUSrc     = alu_src_reg;
  assign ALUCtl     = alu_ctl_reg;
  assign Halt       = halt_reg;

endmodule
